adder_seq_ctrl: RTL and testbench

Sequencer that time-multiplexes one combinational NUM-input adder over a long vector. The vector arrives as a stream of NUM-element chunks. The block sums each chunk with an internal adder instance and accumulates the partial sums in a register. When the programmed chunk count has been consumed, it presents one WIDTH-bit result. It sits between the layer-memory read stream and the activation stage of a neuron, for dot-product and gradient reductions.

---
 rtl/adder_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Chunked reduction sequencer: one NUM-input adder summed over a stream of chunks into an accumulator.
// Optional macro ADDER_SEQ_SAT_EN: saturating accumulation with a sticky ovf flag.
module adder_seq_add #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32
) (
  input  logic [NUM*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     total
);
  logic [NUM:0][WIDTH-1:0] part;

  assign part[0] = '0;
  for (genvar j = 0; j < NUM; j++) begin : g_chain
    assign part[j+1] = part[j] + in_data[WIDTH*j +: WIDTH];
  end
  assign total = part[NUM];
endmodule

module adder_seq_ctrl #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CW-1:0]        num_chunks,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic                 busy,
  output logic                 ovf
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, chunk_sum, acc_step;
  logic [CW-1:0]    remaining;
  logic             step_clamp, ovf_q, hs, last;

  adder_seq_add #(.NUM(NUM), .WIDTH(WIDTH)) u_add (
    .in_data (in_data),
    .total   (chunk_sum)
  );

  assign hs   = in_valid & in_ready;
  assign last = (remaining == CW'(1));

`ifdef ADDER_SEQ_SAT_EN
  logic [WIDTH:0] wide;

  // chunk_sum is already wrapped by the adder; only the accumulate step clamps
  always_comb begin
    wide       = {acc[WIDTH-1], acc} + {chunk_sum[WIDTH-1], chunk_sum};
    step_clamp = wide[WIDTH] != wide[WIDTH-1];
    acc_step   = wide[WIDTH-1:0];
    if (step_clamp)
      acc_step = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign acc_step   = acc + chunk_sum;
  assign step_clamp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_chunks != '0) ? ACC : DONE;
      end
      ACC: begin
        in_ready = 1'b1;
        if (hs && last) state_nxt = DONE;
      end
      DONE: if (sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc       <= '0;
          remaining <= num_chunks;
          ovf_q     <= 1'b0;
          if (num_chunks == '0) begin
            sum       <= '0;
            sum_valid <= 1'b1;
          end
        end
        ACC: if (hs) begin
          acc       <= acc_step;
          remaining <= remaining - CW'(1);
          if (step_clamp) ovf_q <= 1'b1;
          if (last) begin
            sum       <= acc_step;
            sum_valid <= 1'b1;
          end
        end
        DONE: if (sum_ready) sum_valid <= 1'b0;
        default: ;
      endcase
    end

  assign ovf = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: expected {ovf,sum} queued at start, checked when the result appears.
module tb_adder_seq_ctrl;
  localparam int NUM = 4;
  localparam int W   = 32;
  localparam int CW  = 8;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, sum_ready;
  logic [CW-1:0]     num_chunks;
  logic [NUM*W-1:0]  in_data;
  logic              in_ready, sum_valid, busy, ovf;
  logic [W-1:0]      sum;

  logic [NUM*W-1:0]  chunks[$];
  logic [W:0]        exp_q[$];
  int                n_vec = 0, n_err = 0;

  adder_seq_ctrl #(.NUM(NUM), .WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference reduction over the first n entries of chunks
  function automatic logic [W:0] model(input int n);
    logic signed [W-1:0] a, cs;
    logic                o;
    longint              t;
    a = '0; o = 1'b0;
    for (int i = 0; i < n; i++) begin
      cs = '0;
      for (int j = 0; j < NUM; j++) cs += chunks[i][W*j +: W];
`ifdef ADDER_SEQ_SAT_EN
      t = longint'(a) + longint'(cs);
      if (t > MAXV)      begin t = MAXV; o = 1'b1; end
      else if (t < MINV) begin t = MINV; o = 1'b1; end
      a = t[W-1:0];
`else
      t = 0;
      a = a + cs;
`endif
    end
    return {o, a};
  endfunction

  task automatic fill_rand(input int n);
    chunks.delete();
    for (int i = 0; i < n; i++)
      chunks.push_back(pack4($urandom, $urandom, $urandom, $urandom));
  endtask

  task automatic run(input int n, input int bub_max, input int stall, input bit poke);
    logic [W:0] e;
    int t;
    exp_q.push_back(model(n));
    @(posedge clk); #1; start = 1'b1; num_chunks = CW'(n);
    @(posedge clk); #1; start = 1'b0;
    chk(n == 0 ? "zero_no_ready" : "start_ready", {63'd0, in_ready}, n == 0 ? 64'd0 : 64'd1);
    for (int i = 0; i < n; i++) begin
      if (bub_max > 0)
        repeat ($urandom_range(bub_max, 0)) begin
          in_valid = 1'b0; start = poke;
          @(posedge clk); #1; start = 1'b0;
          chk("bubble_ready", {63'd0, in_ready}, 64'd1);
        end
      in_valid = 1'b1; in_data = chunks[i];
      t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (t == 20) chk("hs_timeout", 64'(t), 64'd0);
      if (i == n-1) chk("early_valid", {63'd0, sum_valid}, 64'd0);
      @(posedge clk); #1; in_valid = 1'b0;
    end
    chk("valid_latency", {63'd0, sum_valid}, 64'd1);
    t = 0;
    while (!sum_valid && t < 20) begin @(posedge clk); #1; t++; end
    e = exp_q.pop_front();
    chk("sum", 64'(sum), 64'(e[W-1:0]));
    chk("ovf", {63'd0, ovf}, {63'd0, e[W]});
    chk("busy_done", {63'd0, busy}, 64'd1);
    chk("done_no_ready", {63'd0, in_ready}, 64'd0);
    repeat (stall) begin
      start = poke;
      @(posedge clk); #1; start = 1'b0;
      chk("stall_sum", 64'(sum), 64'(e[W-1:0]));
      chk("stall_valid", {63'd0, sum_valid}, 64'd1);
    end
    sum_ready = 1'b1;
    @(posedge clk); #1; sum_ready = 1'b0;
    chk("taken_valid", {63'd0, sum_valid}, 64'd0);
    chk("taken_busy", {63'd0, busy}, 64'd0);
    chk("sum_kept", 64'(sum), 64'(e[W-1:0]));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_chunks = '0; in_data = '0;
    in_valid = 1'b0; sum_ready = 1'b0;
    #12;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", {60'd0, sum_valid, in_ready, busy, ovf}, 64'd0);
    rst_n = 1'b1;

    // directed: 10 + 26 + (-4) = 32
    chunks.delete();
    chunks.push_back(pack4(1, 2, 3, 4));
    chunks.push_back(pack4(5, 6, 7, 8));
    chunks.push_back(pack4('1, '1, '1, '1));
    run(3, 0, 0, 1'b0);
    chk("directed_model", 64'(exp_q.size()), 64'd0);

    run(0, 0, 2, 1'b1);

    // bubbles, 5-cycle result stall, stray start pulses
    fill_rand(4);
    run(4, 3, 5, 1'b1);

    // abort mid-reduction: 2 of 4 chunks then async reset
    fill_rand(4);
    @(posedge clk); #1; start = 1'b1; num_chunks = 4;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1; in_data = chunks[0];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_flags", {60'd0, sum_valid, in_ready, busy, ovf}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    fill_rand(3);
    run(3, 1, 1, 1'b0);

    // 0x2000_0000 x4 per chunk: wraps to 0, or clamps low under saturation
    chunks.delete();
    repeat (2) chunks.push_back(pack4(32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000));
    run(2, 0, 0, 1'b0);
    // 0x1000_0000 x4: 0x8000_0000 wrap, or clamp to max
    chunks.delete();
    repeat (2) chunks.push_back(pack4(32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000));
    run(2, 0, 0, 1'b0);
    // ovf cleared by the next start
    chunks.delete();
    chunks.push_back(pack4(1, 1, 1, 1));
    run(1, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(6, 1);
      fill_rand(n);
      run(n, 2, $urandom_range(3, 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
